// File: rtl/rip_axi_interface_const.sv
// Shared AXI4 encodings and field widths for the rip AXI blocks.
package rip_axi_interface_const;

    localparam int AXI_LEN_WIDTH  = 8;
    localparam int AXI_SIZE_WIDTH = 3;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

endpackage

// File: rtl/rip_axi_burst_addr_gen.sv
// Combinational next-beat address for AXI FIXED / INCR / WRAP bursts.
module rip_axi_burst_addr_gen
    import rip_axi_interface_const::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [AXI_SIZE_WIDTH-1:0] size,
    input  logic [AXI_LEN_WIDTH-1:0]  len,
    input  axi_burst_t                burst,
    output logic [ADDR_WIDTH-1:0]     next
);

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] low;
    logic [ADDR_WIDTH-1:0] incr;

    always_comb begin
        bytes = ADDR_WIDTH'(1) << size;
        span  = ({{(ADDR_WIDTH-AXI_LEN_WIDTH){1'b0}}, len} + ADDR_WIDTH'(1)) << size;
        // Wrap boundary is the span-aligned window holding the current address.
        low   = addr & ~(span - ADDR_WIDTH'(1));
        incr  = addr + bytes;
        case (burst)
            AXI_BURST_FIXED: next = addr;
            AXI_BURST_WRAP:  next = (incr == low + span) ? low : incr;
            default:         next = incr;
        endcase
    end

endmodule

// File: rtl/rip_axi_rd_responder.sv
// AXI4 read-channel slave: one burst at a time, one R beat every two cycles from a 1-cycle memory.
// Optional macro RIP_AXI_RD_WRAP_CHECK_EN rejects illegal WRAP bursts with SLVERR.
module rip_axi_rd_responder
    import rip_axi_interface_const::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 'h0,
    parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 'h10000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ID_WIDTH-1:0]       arid,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [AXI_LEN_WIDTH-1:0]  arlen,
    input  logic [AXI_SIZE_WIDTH-1:0] arsize,
    input  logic [1:0]                arburst,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [ID_WIDTH-1:0]       rid,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      mem_re,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int                    BUS_SIZE   = $clog2(DATA_WIDTH/8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(DATA_WIDTH/8 - 1));

    logic [1:0]                state_q, state_d;
    logic                      arready_q, arready_d;
    logic [ID_WIDTH-1:0]       id_q, id_d;
    logic [AXI_LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                      slverr_q, slverr_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    axi_resp_t                 rresp_q, rresp_d;
    logic                      rlast_q, rlast_d;

    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [AXI_LEN_WIDTH-1:0]  len_q, len_d;
    logic [AXI_SIZE_WIDTH-1:0] size_q, size_d;
    axi_burst_t                burst_q, burst_d;

    logic [ADDR_WIDTH-1:0]     next_addr;
    logic [ADDR_WIDTH:0]       base_off;
    logic                      in_range;
    logic                      burst_err;
    axi_resp_t                 beat_resp;

    rip_axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr  (addr_q),
        .size  (size_q),
        .len   (len_q),
        .burst (burst_q),
        .next  (next_addr)
    );

    // Subtract with a borrow bit so a zero base needs no always-true compare.
    always_comb begin
        base_off  = {1'b0, addr_q} - {1'b0, MEM_BASE};
        in_range  = !base_off[ADDR_WIDTH] && (base_off[ADDR_WIDTH-1:0] < MEM_SIZE);
        if (slverr_q) begin
            beat_resp = AXI_RESP_SLVERR;
        end else if (!in_range) begin
            beat_resp = AXI_RESP_DECERR;
        end else begin
            beat_resp = AXI_RESP_OKAY;
        end
    end

    always_comb begin
        burst_err = (arburst == AXI_BURST_RSVD) || (arsize > AXI_SIZE_WIDTH'(BUS_SIZE));
`ifdef RIP_AXI_RD_WRAP_CHECK_EN
        if (arburst == AXI_BURST_WRAP) begin
            if (!(arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
                burst_err = 1'b1;
            end
            if ((araddr & ((ADDR_WIDTH'(1) << arsize) - ADDR_WIDTH'(1))) != '0) begin
                burst_err = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        beat_cnt_d = beat_cnt_q;
        slverr_d   = slverr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (arvalid && arready_q) begin
                    id_d       = arid;
                    addr_d     = araddr;
                    len_d      = arlen;
                    size_d     = arsize;
                    burst_d    = axi_burst_t'(arburst);
                    beat_cnt_d = '0;
                    slverr_d   = burst_err;
                    state_d    = ST_MEM;
                end
            end
            ST_MEM: begin
                rdata_d = (beat_resp == AXI_RESP_OKAY) ? mem_rdata : '0;
                rresp_d = beat_resp;
                rlast_d = (beat_cnt_q == len_q);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rready) begin
                    if (rlast_q) begin
                        rlast_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d     = next_addr;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        state_d    = ST_MEM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        arready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            arready_q  <= 1'b0;
            id_q       <= '0;
            beat_cnt_q <= '0;
            slverr_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= AXI_RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            arready_q  <= arready_d;
            id_q       <= id_d;
            beat_cnt_q <= beat_cnt_d;
            slverr_q   <= slverr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    // Burst descriptor is only meaningful while a burst is active.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        len_q   <= len_d;
        size_q  <= size_d;
        burst_q <= burst_d;
    end

    assign arready  = arready_q;
    assign rvalid   = (state_q == ST_RESP);
    assign rid      = id_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign rlast    = rlast_q;
    assign mem_re   = (state_q == ST_MEM) && (beat_resp == AXI_RESP_OKAY);
    assign mem_addr = addr_q & ALIGN_MASK;

endmodule

// File: tb/tb_rip_axi_rd_responder.sv
// Bench for rip_axi_rd_responder: directed vector table, hand sequences and random bursts vs a model.
module tb_rip_axi_rd_responder;
    import rip_axi_interface_const::*;

    localparam logic [31:0] MBASE = 32'h0;
    localparam logic [31:0] MSIZE = 32'h10000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign mem_rdata = memf(mem_addr);

    rip_axi_rd_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .ID_WIDTH   (4),
        .MEM_BASE   (MBASE),
        .MEM_SIZE   (MSIZE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]       id;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        int               stall;
        logic [3:0][31:0] ea;
        logic [3:0][1:0]  er;
    } vec_t;

    vec_t        tbl [11];
    logic [31:0] e_addr [16];
    logic [1:0]  e_resp [16];

    task automatic setv(input int k, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                        input int stall, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] a3, input logic [1:0] r0,
                        input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] r3);
        tbl[k].id    = id;
        tbl[k].addr  = addr;
        tbl[k].len   = len;
        tbl[k].size  = size;
        tbl[k].burst = burst;
        tbl[k].stall = stall;
        tbl[k].ea    = {a3, a2, a1, a0};
        tbl[k].er    = {r3, r2, r1, r0};
    endtask

    // Reference: beat addresses from closed-form burst arithmetic, responses from the error rules.
    task automatic model(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
        logic [31:0] bytes, span, low, a;
        logic        slv;
        bytes = 32'd1 << size;
        span  = (32'(len) + 1) * bytes;
        low   = addr - (addr % span);
        slv   = (burst == 2'b11) || (size > 3'd2);
        for (int i = 0; i <= int'(len); i++) begin
            if (burst == 2'b00)      a = addr;
            else if (burst == 2'b10) a = low + ((addr - low + 32'(i) * bytes) % span);
            else                     a = addr + 32'(i) * bytes;
            e_addr[i] = a & ~32'd3;
            if (slv)                                   e_resp[i] = 2'b10;
            else if (a >= MBASE && a < MBASE + MSIZE)  e_resp[i] = 2'b00;
            else                                       e_resp[i] = 2'b11;
        end
    endtask

    task automatic run_burst(input string nm, input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int stall_beat);
        int          cyc;
        logic        saw_re;
        logic [31:0] re_addr;
        logic [35:0] held;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1; rready = 1'b1;
        cyc = 0;
        while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
        chk({nm, " arready"}, 64'(arready), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            saw_re = 1'b0; re_addr = '0; cyc = 0;
            while (!rvalid && cyc < 10) begin
                if (mem_re) begin saw_re = 1'b1; re_addr = mem_addr; end
                @(negedge clk);
                cyc++;
            end
            if (!rvalid) begin
                chk({nm, " rvalid timeout"}, 64'd0, 64'd1);
                return;
            end
            chk({nm, " beat spacing"}, 64'(cyc), 64'd1);
            chk({nm, " rid"}, 64'(rid), 64'(id));
            chk({nm, " rresp"}, 64'(rresp), 64'(e_resp[b]));
            chk({nm, " rlast"}, 64'(rlast), 64'(b == int'(len)));
            chk({nm, " rdata"}, 64'(rdata), (e_resp[b] == 2'b00) ? 64'(memf(e_addr[b])) : 64'd0);
            chk({nm, " mem_re"}, 64'(saw_re), 64'(e_resp[b] == 2'b00));
            if (e_resp[b] == 2'b00) chk({nm, " mem_addr"}, 64'(re_addr), 64'(e_addr[b]));
            if (b == stall_beat) begin
                rready = 1'b0;
                held = {rvalid, rlast, rresp, rdata};
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk({nm, " stall hold"}, 64'({rvalid, rlast, rresp, rdata}), 64'(held));
                end
                rready = 1'b1;
            end
            @(negedge clk);
        end
        chk({nm, " end rvalid"}, 64'(rvalid), 64'd0);
        chk({nm, " end arready"}, 64'(arready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          hi;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] addr;
        int          stall;

        rst = 1'b1; arvalid = 1'b0; rready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;

        setv(0, 4'h1, 32'h100, 8'd3, 3'd2, 2'b01, 1, 32'h100, 32'h104, 32'h108, 32'h10C, 0, 0, 0, 0);
        setv(1, 4'h2, 32'h108, 8'd3, 3'd2, 2'b10, -1, 32'h108, 32'h10C, 32'h100, 32'h104, 0, 0, 0, 0);
        setv(2, 4'h5, 32'h20, 8'd2, 3'd2, 2'b00, -1, 32'h20, 32'h20, 32'h20, 0, 0, 0, 0, 0);
        setv(3, 4'h3, 32'hFFF8, 8'd3, 3'd2, 2'b01, -1, 32'hFFF8, 32'hFFFC, 32'h10000, 32'h10004, 0, 0, 3, 3);
        setv(4, 4'h4, 32'h40, 8'd1, 3'd2, 2'b11, -1, 0, 0, 0, 0, 2, 2, 0, 0);
        setv(5, 4'h6, 32'h80, 8'd2, 3'd3, 2'b01, -1, 0, 0, 0, 0, 2, 2, 2, 0);
`ifdef RIP_AXI_RD_WRAP_CHECK_EN
        setv(6, 4'h7, 32'h100, 8'd2, 3'd2, 2'b10, -1, 0, 0, 0, 0, 2, 2, 2, 0);
`else
        setv(6, 4'h7, 32'h100, 8'd2, 3'd2, 2'b10, -1, 32'h100, 32'h104, 32'h108, 0, 0, 0, 0, 0);
`endif
        setv(7, 4'h8, 32'h103, 8'd1, 3'd0, 2'b01, -1, 32'h100, 32'h104, 0, 0, 0, 0, 0, 0);
        setv(8, 4'h9, 32'h106, 8'd1, 3'd1, 2'b10, -1, 32'h104, 32'h104, 0, 0, 0, 0, 0, 0);
        setv(9, 4'hA, 32'h40, 8'd0, 3'd2, 2'b01, -1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        setv(10, 4'hB, 32'h10002, 8'd1, 3'd1, 2'b00, -1, 0, 0, 0, 0, 3, 3, 0, 0);

        #2;
        chk("reset arready", 64'(arready), 64'd0);
        chk("reset rvalid", 64'(rvalid), 64'd0);
        chk("reset rlast", 64'(rlast), 64'd0);
        chk("reset rresp", 64'(rresp), 64'd0);
        chk("reset rdata", 64'(rdata), 64'd0);
        chk("reset rid", 64'(rid), 64'd0);
        chk("reset mem_re", 64'(mem_re), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset arready", 64'(arready), 64'd1);

        for (int k = 0; k < 11; k++) begin
            for (int i = 0; i <= int'(tbl[k].len); i++) begin
                e_addr[i] = tbl[k].ea[i];
                e_resp[i] = tbl[k].er[i];
            end
            run_burst($sformatf("vec%0d", k), tbl[k].id, tbl[k].addr, tbl[k].len,
                      tbl[k].size, tbl[k].burst, tbl[k].stall);
        end

        // Reset asserted while beat 1 of an 8-beat burst is presented.
        arid = 4'hC; araddr = 32'h300; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1; rready = 1'b1;
        cyc = 0;
        while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
        arvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            if (b == 1) @(negedge clk);
            cyc = 0;
            while (!rvalid && cyc < 10) begin @(negedge clk); cyc++; end
        end
        chk("midrst rvalid before", 64'(rvalid), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst rvalid", 64'(rvalid), 64'd0);
        chk("midrst arready", 64'(arready), 64'd0);
        chk("midrst rdata", 64'(rdata), 64'd0);
        chk("midrst rid", 64'(rid), 64'd0);
        chk("midrst mem_re", 64'(mem_re), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid || mem_re) hi++;
        end
        chk("midrst no beats after", 64'(hi), 64'd0);
        chk("midrst arready after", 64'(arready), 64'd1);

        for (int n = 0; n < 40; n++) begin
            burst = 2'($urandom_range(0, 3));
            size  = 3'($urandom_range(0, 3));
            if (burst == 2'b10) begin
                case ($urandom_range(0, 3))
                    0: len = 8'd1;
                    1: len = 8'd3;
                    2: len = 8'd7;
                    default: len = 8'd15;
                endcase
            end else begin
                len = 8'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) addr = 32'h10000 - 32'($urandom_range(0, 32));
            else addr = 32'($urandom_range(0, 32'h10100));
            if (burst == 2'b10) addr = addr & ~((32'd1 << size) - 1);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(len))) : -1;
            model(addr, len, size, burst);
            run_burst($sformatf("rnd%0d", n), 4'($urandom_range(0, 15)), addr, len, size, burst, stall);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
